scan_cfg_driver: RTL and testbench
==================================

// Module: scan_cfg_driver
// PURPOSE
//  Host-side master for the fabric configuration scan chain (the chain of sram shift regs inside clb/ble).
//  Takes parallel config words over a valid/ready stream, serialises them onto scan_out with a generated
//  scan_clk/scan_en, and returns the old chain contents from the chain tail (scan_in) as readback words.
//  Sits between the bitstream source (host/ROM) and the fabric scan port.
// PARAMETERS
//  WORD_W     16  config/readback word width
//  CHAIN_LEN  29  total scan chain length in bits (13 + 16 for one clb); >= 1
//  CNT_W      16  bit-counter width; 2**CNT_W > CHAIN_LEN
//  HALF_DIV   1   scan_clk half-period in clk cycles; >= 1
// PORTS
//  clk       in   1       system clock
//  reset     in   1       asynchronous, active-high reset
//  start     in   1       1-cycle request to begin a full chain load; ignored while busy
//  busy      out  1       high from the cycle after an accepted start until done
//  done      out  1       1-cycle pulse when the last bit is shifted and the readback is flushed
//  wr_data   in   WORD_W  config word, LSB shifted first
//  wr_valid  in   1       wr_data valid
//  wr_ready  out  1       driver accepts wr_data this cycle
//  rd_data   out  WORD_W  readback word, LSB = first bit returned
//  rd_valid  out  1       rd_data valid; held with data stable until rd_ready
//  rd_ready  in   1       consumer accepts rd_data
//  scan_clk  out  1       registered scan clock to fabric
//  scan_en   out  1       scan enable to fabric
//  scan_out  out  1       serial data to the fabric chain head (fabric scan_in)
//  scan_in   in   1       serial data from the fabric chain tail (fabric scan_out)
// BEHAVIOUR
//  - Reset values: busy=0 done=0 wr_ready=0 rd_valid=0 rd_data=0 scan_clk=0 scan_en=0 scan_out=0.
//  - Reset mid-operation clears everything immediately; the chain contents are undefined afterwards and
//    no done is produced.
//  - FSM: IDLE -> (start) FETCH -> LOW -> HIGH -> LOW ... -> FLUSH -> DONE -> IDLE.
//  - IDLE: scan_en=0, scan_clk=0. start latches bit_cnt=0 and enters FETCH.
//  - Write side: one-word holding buffer. wr_ready = busy && buffer empty; a transfer occurs when
//    wr_valid && wr_ready. NW = ceil(CHAIN_LEN/WORD_W) words are accepted per load.
//  - Stream order: stream bit k = word k/WORD_W, bit k%WORD_W. Bits of the last word beyond CHAIN_LEN
//    are discarded.
//  - FETCH: scan_en=1, scan_clk=0. Waits until the shift register holds the next bit (loaded from the
//    buffer at the word boundary), then goes to LOW.
//  - LOW (HALF_DIV cycles): scan_out = current bit, scan_clk=0.
//  - HIGH (HALF_DIV cycles): scan_clk=1.
//    * scan_in is sampled in the clk cycle in which scan_clk goes 0->1, and packed into the readback word.
//    * bit_cnt increments on that edge.
//    * scan_out is stable for the whole of LOW and HIGH.
//  - After HIGH: if bit_cnt == CHAIN_LEN go to FLUSH. Otherwise, at a word boundary with the buffer empty,
//    go to FETCH (stall: scan_clk held 0, scan_en held 1); else go to LOW with the next bit.
//  - Readback:
//    * A completed WORD_W-bit word moves to rd_data with rd_valid=1.
//    * If rd_valid is still set when the next word completes, the driver stalls in LOW (no rising edge)
//      until rd_ready.
//    * rd_valid clears on rd_valid && rd_ready.
//  - FLUSH:
//    * scan_en=0, scan_clk=0.
//    * A partial readback word (CHAIN_LEN % WORD_W != 0) is emitted with its upper bits zero.
//    * The state waits until rd_valid is clear.
//  - DONE: done=1 for one cycle, busy=0 next cycle.
//  - Exactly CHAIN_LEN scan_clk rising edges per load. scan_en rises >= 1 clk before the first rising edge
//    and falls >= HALF_DIV clk after the last.
//  - start coincident with DONE is ignored. Extra wr beats after NW words are not accepted (wr_ready=0).
// TESTING
//  1. WORD_W=4, CHAIN_LEN=8, HALF_DIV=1; chain model preloaded 8'hA5; write 4'h3, 4'hC:
//     -> rd words 4'h5 then 4'hA; chain = 8'hC3; done after 8 scan_clk edges.
//  2. CHAIN_LEN=6; write 4'hF, 4'hF:
//     -> exactly 6 scan_clk edges, chain = 6'h3F; second rd word is 2 valid bits with upper 2 bits zero.
//  3. Hold wr_valid=0 for 10 cycles after the first word:
//     -> scan_clk stays 0, scan_en stays 1, no edges; the load resumes and completes correctly.
//  4. Hold rd_ready=0 after the first rd word:
//     -> shifting stalls with scan_clk=0 before the next word completes; rd_data stable; done only after
//        both words are accepted.
//  5. Assert reset during the 3rd bit:
//     -> all outputs go to reset values immediately; no done; a new start performs a full correct load.
//  6. HALF_DIV=3, start pulsed while busy:
//     -> scan_clk high/low phases are 3 cycles each; the second start is ignored (one done only).

Source files
------------

// File: rtl/scan_cfg_driver.sv
// rtl/scan_cfg_driver.sv - configuration scan-chain master: word stream in, serial shift with
// generated scan_clk/scan_en, old chain contents returned as a readback word stream.
module scan_cfg_driver #(
   parameter int WORD_W    = 16,
   parameter int CHAIN_LEN = 29,
   parameter int CNT_W     = 16,
   parameter int HALF_DIV  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              scan_clk,
   output logic              scan_en,
   output logic              scan_out,
   input  logic              scan_in
);
   localparam int NW  = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int WBW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int DVW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] NW_C        = CNT_W'(NW);
   localparam logic [WBW-1:0]   WLAST       = WBW'(WORD_W - 1);
   localparam logic [DVW-1:0]   DLAST       = DVW'(HALF_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOW,
      S_HIGH,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]  words_q, words_d;
   logic [WBW-1:0]    wbit_q, wbit_d;
   logic [DVW-1:0]    div_q, div_d;
   logic [WORD_W-1:0] buf_q, buf_d;
   logic              buf_full_q, buf_full_d;
   logic [WORD_W-1:0] sh_q, sh_d;
   logic [WORD_W-1:0] rsh_q, rsh_d;
   logic [WORD_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              scan_clk_q, scan_clk_d;
   logic              scan_en_q, scan_en_d;
   logic              scan_out_q, scan_out_d;

   logic              wr_fire;
   logic              rd_free;
   logic              can_rise;

   assign wr_ready = busy_q && !buf_full_q && (words_q < NW_C);
   assign wr_fire  = wr_valid && wr_ready;
   assign rd_free  = !rd_valid_q || rd_ready;
   // A rising edge that completes a readback word needs somewhere to put it.
   assign can_rise = (wbit_q != WLAST) || rd_free;

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign scan_clk = scan_clk_q;
   assign scan_en  = scan_en_q;
   assign scan_out = scan_out_q;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      words_d    = words_q;
      wbit_d     = wbit_q;
      div_d      = div_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      sh_d       = sh_q;
      rsh_d      = rsh_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q && !rd_ready;
      scan_out_d = scan_out_q;

      if (wr_fire) begin
         buf_d      = wr_data;
         buf_full_d = 1'b1;
         words_d    = words_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               bit_cnt_d  = '0;
               words_d    = '0;
               wbit_d     = '0;
               rsh_d      = '0;
               buf_full_d = 1'b0;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: begin
            if (buf_full_q) begin
               sh_d       = buf_q;
               buf_full_d = 1'b0;
               div_d      = '0;
               state_d    = S_LOW;
            end
         end
         S_LOW: begin
            if (div_q != DLAST) begin
               div_d = div_q + DVW'(1);
            end else if (can_rise) begin
               // Rising edge: capture the chain tail, advance counters and shifter.
               div_d         = '0;
               state_d       = S_HIGH;
               rsh_d[wbit_q] = scan_in;
               bit_cnt_d     = bit_cnt_q + CNT_W'(1);
               sh_d          = sh_q >> 1;
               if (wbit_q == WLAST) begin
                  rd_data_d  = rsh_d;
                  rd_valid_d = 1'b1;
                  rsh_d      = '0;
                  wbit_d     = '0;
               end else begin
                  wbit_d = wbit_q + WBW'(1);
               end
            end
         end
         S_HIGH: begin
            if (div_q != DLAST) begin
               div_d = div_q + DVW'(1);
            end else begin
               div_d = '0;
               if (bit_cnt_q == CHAIN_LEN_C) begin
                  state_d = S_FLUSH;
               end else if (wbit_q == '0) begin
                  if (buf_full_q) begin
                     sh_d       = buf_q;
                     buf_full_d = 1'b0;
                     state_d    = S_LOW;
                  end else begin
                     state_d = S_FETCH;
                  end
               end else begin
                  state_d = S_LOW;
               end
            end
         end
         S_FLUSH: begin
            // Leftover bits form a short final word whose upper bits stay zero.
            if (wbit_q != '0) begin
               if (rd_free) begin
                  rd_data_d  = rsh_q;
                  rd_valid_d = 1'b1;
                  rsh_d      = '0;
                  wbit_d     = '0;
               end
            end else if (rd_free) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if ((state_d == S_LOW) && (state_q != S_LOW)) begin
         scan_out_d = sh_d[0];
      end

      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      scan_clk_d = (state_d == S_HIGH);
      scan_en_d  = (state_d == S_FETCH) || (state_d == S_LOW) || (state_d == S_HIGH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         words_q    <= '0;
         wbit_q     <= '0;
         div_q      <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         sh_q       <= '0;
         rsh_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         scan_clk_q <= 1'b0;
         scan_en_q  <= 1'b0;
         scan_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         words_q    <= words_d;
         wbit_q     <= wbit_d;
         div_q      <= div_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         sh_q       <= sh_d;
         rsh_q      <= rsh_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         scan_clk_q <= scan_clk_d;
         scan_en_q  <= scan_en_d;
         scan_out_q <= scan_out_d;
      end
   end

endmodule

// File: tb/tb_scan_cfg_driver.sv
// tb/tb_scan_cfg_driver.sv - directed bench for scan_cfg_driver with behavioural fabric chain models.
module tb_scan_cfg_driver;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic       reset0, start0, busy0, done0, wr_valid0, wr_ready0, rd_valid0, rd_ready0;
   logic       scan_clk0, scan_en0, scan_out0, scan_in0;
   logic [3:0] wr_data0, rd_data0;
   logic       reset1, start1, busy1, done1, wr_valid1, wr_ready1, rd_valid1, rd_ready1;
   logic       scan_clk1, scan_en1, scan_out1, scan_in1;
   logic [3:0] wr_data1, rd_data1;

   scan_cfg_driver #(.WORD_W(4), .CHAIN_LEN(8), .CNT_W(8), .HALF_DIV(1)) u0 (
      .clk(clk), .reset(reset0), .start(start0), .busy(busy0), .done(done0),
      .wr_data(wr_data0), .wr_valid(wr_valid0), .wr_ready(wr_ready0),
      .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready0),
      .scan_clk(scan_clk0), .scan_en(scan_en0), .scan_out(scan_out0), .scan_in(scan_in0));

   scan_cfg_driver #(.WORD_W(4), .CHAIN_LEN(6), .CNT_W(8), .HALF_DIV(3)) u1 (
      .clk(clk), .reset(reset1), .start(start1), .busy(busy1), .done(done1),
      .wr_data(wr_data1), .wr_valid(wr_valid1), .wr_ready(wr_ready1),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ready(rd_ready1),
      .scan_clk(scan_clk1), .scan_en(scan_en1), .scan_out(scan_out1), .scan_in(scan_in1));

   // Fabric chain models: head takes scan_out, tail (bit 0) drives scan_in.
   logic [7:0] chain0, preload0;
   logic [5:0] chain1, preload1;
   logic       load0 = 1'b0;
   logic       load1 = 1'b0;
   always @(posedge scan_clk0 or posedge load0)
      if (load0) chain0 <= preload0;
      else if (scan_en0) chain0 <= {scan_out0, chain0[7:1]};
   always @(posedge scan_clk1 or posedge load1)
      if (load1) chain1 <= preload1;
      else if (scan_en1) chain1 <= {scan_out1, chain1[5:1]};
   assign scan_in0 = chain0[0];
   assign scan_in1 = chain1[0];

   int edges0 = 0;
   int edges1 = 0;
   int dones0 = 0;
   int dones1 = 0;
   always @(posedge scan_clk0) edges0 <= edges0 + 1;
   always @(posedge scan_clk1) edges1 <= edges1 + 1;
   always @(posedge clk) if (done0 === 1'b1) dones0 <= dones0 + 1;
   always @(posedge clk) if (done1 === 1'b1) dones1 <= dones1 + 1;

   // Phase-length monitor for u1, sampled on the falling edge.
   logic mon_clr = 1'b0;
   int hi_run, lo_run, hi_min, hi_max, lo_min;
   always @(negedge clk) begin
      if (mon_clr) begin
         hi_run <= 0; lo_run <= 0; hi_min <= 99; hi_max <= 0; lo_min <= 99;
      end else if (scan_clk1 === 1'b1) begin
         if (lo_run > 0 && lo_run < lo_min) lo_min <= lo_run;
         lo_run <= 0;
         hi_run <= hi_run + 1;
      end else begin
         if (hi_run > 0) begin
            if (hi_run < hi_min) hi_min <= hi_run;
            if (hi_run > hi_max) hi_max <= hi_run;
         end
         hi_run <= 0;
         lo_run <= (scan_en1 === 1'b1) ? lo_run + 1 : 0;
      end
   end

   task automatic pulse_start0;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
   endtask

   task automatic pulse_start1;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
   endtask

   task automatic write_word0(input logic [3:0] w);
      int t = 0;
      wr_data0 = w; wr_valid0 = 1'b1;
      while (wr_ready0 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      checks++;
      if (t >= 300) begin failures++; $display("FAIL wr0_timeout waited=%0d limit=300", t); end
      @(negedge clk); wr_valid0 = 1'b0;
   endtask

   task automatic write_word1(input logic [3:0] w);
      int t = 0;
      wr_data1 = w; wr_valid1 = 1'b1;
      while (wr_ready1 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      checks++;
      if (t >= 300) begin failures++; $display("FAIL wr1_timeout waited=%0d limit=300", t); end
      @(negedge clk); wr_valid1 = 1'b0;
   endtask

   task automatic read_word0(output logic [3:0] w);
      int t = 0;
      rd_ready0 = 1'b1;
      while (rd_valid0 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      checks++;
      if (t >= 300) begin failures++; $display("FAIL rd0_timeout waited=%0d limit=300", t); end
      w = rd_data0;
      @(negedge clk); rd_ready0 = 1'b0;
   endtask

   task automatic read_word1(output logic [3:0] w);
      int t = 0;
      rd_ready1 = 1'b1;
      while (rd_valid1 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      checks++;
      if (t >= 300) begin failures++; $display("FAIL rd1_timeout waited=%0d limit=300", t); end
      w = rd_data1;
      @(negedge clk); rd_ready1 = 1'b0;
   endtask

   task automatic wait_done0;
      int t = 0;
      while (done0 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      checks++;
      if (t >= 300) begin failures++; $display("FAIL done0_timeout waited=%0d limit=300", t); end
   endtask

   task automatic wait_done1;
      int t = 0;
      while (done1 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      checks++;
      if (t >= 300) begin failures++; $display("FAIL done1_timeout waited=%0d limit=300", t); end
   endtask

   task automatic test_reset;
      reset0 = 1'b1; reset1 = 1'b1;
      start0 = 1'b0; wr_valid0 = 1'b0; wr_data0 = '0; rd_ready0 = 1'b0;
      start1 = 1'b0; wr_valid1 = 1'b0; wr_data1 = '0; rd_ready1 = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy0, done0, wr_ready0, rd_valid0, rd_data0, scan_clk0, scan_en0, scan_out0} !== 11'd0) begin
         failures++;
         $display("FAIL reset_u0 got=%b want=0", {busy0, done0, wr_ready0, rd_valid0, rd_data0, scan_clk0, scan_en0, scan_out0});
      end
      checks++;
      if ({busy1, done1, wr_ready1, rd_valid1, rd_data1, scan_clk1, scan_en1, scan_out1} !== 11'd0) begin
         failures++;
         $display("FAIL reset_u1 got=%b want=0", {busy1, done1, wr_ready1, rd_valid1, rd_data1, scan_clk1, scan_en1, scan_out1});
      end
      reset0 = 1'b0; reset1 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy0 !== 1'b0 || scan_en0 !== 1'b0) begin
         failures++; $display("FAIL idle_after_reset busy=%b scan_en=%b want=0,0", busy0, scan_en0);
      end
   endtask

   task automatic test_basic_load;
      logic [3:0] r0, r1;
      int e;
      preload0 = 8'hA5; load0 = 1'b1; #1 load0 = 1'b0;
      e = edges0;
      pulse_start0();
      checks++;
      if (busy0 !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy0); end
      write_word0(4'h3);
      write_word0(4'hC);
      read_word0(r0);
      read_word0(r1);
      wait_done0();
      checks++;
      if (r0 !== 4'h5) begin failures++; $display("FAIL basic_rd0 got=%h want=5", r0); end
      checks++;
      if (r1 !== 4'hA) begin failures++; $display("FAIL basic_rd1 got=%h want=a", r1); end
      checks++;
      if (edges0 - e !== 8) begin failures++; $display("FAIL basic_edges got=%0d want=8", edges0 - e); end
      @(negedge clk);
      checks++;
      if (chain0 !== 8'hC3) begin failures++; $display("FAIL basic_chain got=%h want=c3", chain0); end
      checks++;
      if (busy0 !== 1'b0) begin failures++; $display("FAIL basic_busy_after_done got=%b want=0", busy0); end
   endtask

   task automatic test_partial_word;
      logic [3:0] r0, r1;
      int e;
      preload1 = 6'h16; load1 = 1'b1; #1 load1 = 1'b0;
      e = edges1;
      pulse_start1();
      write_word1(4'hF);
      write_word1(4'hF);
      wr_data1 = 4'hF; wr_valid1 = 1'b1;
      @(negedge clk);
      checks++;
      if (wr_ready1 !== 1'b0) begin failures++; $display("FAIL partial_extra_beat wr_ready=%b want=0", wr_ready1); end
      wr_valid1 = 1'b0;
      read_word1(r0);
      read_word1(r1);
      wait_done1();
      @(negedge clk);
      checks++;
      if (r0 !== 4'h6) begin failures++; $display("FAIL partial_rd0 got=%h want=6", r0); end
      checks++;
      if (r1 !== 4'h1) begin failures++; $display("FAIL partial_rd1 got=%h want=1", r1); end
      checks++;
      if (edges1 - e !== 6) begin failures++; $display("FAIL partial_edges got=%0d want=6", edges1 - e); end
      checks++;
      if (chain1 !== 6'h3F) begin failures++; $display("FAIL partial_chain got=%h want=3f", chain1); end
   endtask

   task automatic test_write_stall;
      logic [3:0] r0, r1;
      int e, t;
      preload0 = 8'h5A; load0 = 1'b1; #1 load0 = 1'b0;
      e = edges0;
      pulse_start0();
      write_word0(4'h9);
      t = 0;
      while (edges0 - e < 4 && t < 300) begin @(negedge clk); t++; end
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (scan_clk0 !== 1'b0 || scan_en0 !== 1'b1 || edges0 - e !== 4) begin
            failures++;
            $display("FAIL wstall_hold cyc=%0d scan_clk=%b scan_en=%b edges=%0d want=0,1,4", i, scan_clk0, scan_en0, edges0 - e);
         end
         @(negedge clk);
      end
      write_word0(4'h6);
      read_word0(r0);
      read_word0(r1);
      wait_done0();
      @(negedge clk);
      checks++;
      if ({r1, r0} !== 8'h5A) begin failures++; $display("FAIL wstall_rd got=%h want=5a", {r1, r0}); end
      checks++;
      if (chain0 !== 8'h69) begin failures++; $display("FAIL wstall_chain got=%h want=69", chain0); end
      checks++;
      if (edges0 - e !== 8) begin failures++; $display("FAIL wstall_edges got=%0d want=8", edges0 - e); end
   endtask

   task automatic test_read_stall;
      logic [3:0] r0, r1;
      int e, t;
      preload0 = 8'h3C; load0 = 1'b1; #1 load0 = 1'b0;
      rd_ready0 = 1'b0;
      e = edges0;
      pulse_start0();
      write_word0(4'h7);
      write_word0(4'h1);
      t = 0;
      while (rd_valid0 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (rd_data0 !== 4'hC || done0 !== 1'b0) begin
            failures++; $display("FAIL rstall_hold cyc=%0d rd_data=%h done=%b want=c,0", i, rd_data0, done0);
         end
         @(negedge clk);
      end
      checks++;
      if (edges0 - e !== 7 || scan_clk0 !== 1'b0) begin
         failures++; $display("FAIL rstall_stop edges=%0d scan_clk=%b want=7,0", edges0 - e, scan_clk0);
      end
      read_word0(r0);
      read_word0(r1);
      wait_done0();
      @(negedge clk);
      checks++;
      if ({r1, r0} !== 8'h3C) begin failures++; $display("FAIL rstall_rd got=%h want=3c", {r1, r0}); end
      checks++;
      if (chain0 !== 8'h17) begin failures++; $display("FAIL rstall_chain got=%h want=17", chain0); end
   endtask

   task automatic test_mid_reset;
      logic [3:0] r0, r1;
      int e, t, d;
      preload0 = 8'hFF; load0 = 1'b1; #1 load0 = 1'b0;
      e = edges0;
      pulse_start0();
      write_word0(4'h0);
      t = 0;
      while (edges0 - e < 2 && t < 300) begin @(negedge clk); t++; end
      @(negedge clk);
      checks++;
      if (scan_en0 !== 1'b1) begin failures++; $display("FAIL mreset_pre scan_en=%b want=1", scan_en0); end
      d = dones0;
      reset0 = 1'b1;
      #1;
      checks++;
      if ({busy0, done0, wr_ready0, rd_valid0, rd_data0, scan_clk0, scan_en0, scan_out0} !== 11'd0) begin
         failures++;
         $display("FAIL mreset_outputs got=%b want=0", {busy0, done0, wr_ready0, rd_valid0, rd_data0, scan_clk0, scan_en0, scan_out0});
      end
      repeat (3) @(negedge clk);
      reset0 = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (dones0 !== d) begin failures++; $display("FAIL mreset_no_done got=%0d want=%0d", dones0, d); end
      preload0 = 8'h81; load0 = 1'b1; #1 load0 = 1'b0;
      e = edges0;
      pulse_start0();
      write_word0(4'hE);
      write_word0(4'h2);
      read_word0(r0);
      read_word0(r1);
      wait_done0();
      @(negedge clk);
      checks++;
      if ({r1, r0} !== 8'h81) begin failures++; $display("FAIL mreset_rd got=%h want=81", {r1, r0}); end
      checks++;
      if (chain0 !== 8'h2E) begin failures++; $display("FAIL mreset_chain got=%h want=2e", chain0); end
      checks++;
      if (edges0 - e !== 8) begin failures++; $display("FAIL mreset_edges got=%0d want=8", edges0 - e); end
   endtask

   task automatic test_slow_clock_restart;
      logic [3:0] r0, r1;
      int e, d;
      mon_clr = 1'b1;
      @(negedge clk); @(negedge clk);
      mon_clr = 1'b0;
      preload1 = 6'h2A; load1 = 1'b1; #1 load1 = 1'b0;
      e = edges1;
      d = dones1;
      pulse_start1();
      repeat (2) @(negedge clk);
      pulse_start1();
      write_word1(4'h5);
      write_word1(4'h3);
      read_word1(r0);
      read_word1(r1);
      wait_done1();
      repeat (20) @(negedge clk);
      checks++;
      if (dones1 - d !== 1) begin failures++; $display("FAIL slow_done_count got=%0d want=1", dones1 - d); end
      checks++;
      if (edges1 - e !== 6) begin failures++; $display("FAIL slow_edges got=%0d want=6", edges1 - e); end
      checks++;
      if (chain1 !== 6'h35) begin failures++; $display("FAIL slow_chain got=%h want=35", chain1); end
      checks++;
      if (r0 !== 4'hA || r1 !== 4'h2) begin failures++; $display("FAIL slow_rd got=%h,%h want=a,2", r0, r1); end
      checks++;
      if (hi_min !== 3 || hi_max !== 3) begin failures++; $display("FAIL slow_high_phase min=%0d max=%0d want=3,3", hi_min, hi_max); end
      checks++;
      if (lo_min !== 3) begin failures++; $display("FAIL slow_low_phase got=%0d want=3", lo_min); end
      checks++;
      if (busy1 !== 1'b0) begin failures++; $display("FAIL slow_busy_after got=%b want=0", busy1); end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_partial_word();
      test_write_stall();
      test_read_stall();
      test_mid_reset();
      test_slow_clock_restart();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog elapsed=400000 limit=400000");
      $fatal(1, "watchdog");
   end
endmodule
